// File: rtl/mips_board_pkg.sv
// Shared types and constants for the board-level instruction loader.
// Holds the UART receiver state encoding and the oversampling/word geometry.
package mips_board_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int OVERSAMPLE     = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int MID_TICK       = 8;

    // Rounded clocks-per-oversample-tick, never below one clock.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchroniser, oversample tick generator and frame FSM.
// Emits one-cycle byte_vld / frm_err pulses when a stop bit is sampled.
module uart_rx_core
    import mips_board_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       en,
    input  logic       rxd,
    output logic       tick,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       frm_err,
    output logic       busy
);

    localparam int DIV         = calc_div(CLK_HZ, BAUD);
    localparam int DIV_W       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SYNC_STAGES = 2;

    logic [DIV_W-1:0]       div_cnt_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    rx_state_t  state_reg, state_next;
    logic [3:0] tcnt_reg, tcnt_next;
    logic [2:0] bitn_reg, bitn_next;
    logic [7:0] data_reg, data_next;
    logic       byte_vld_reg, byte_vld_next;
    logic       frm_err_reg, frm_err_next;

    assign tick = (div_cnt_reg == DIV_W'(DIV - 1));
    assign rx_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (srst) begin
            div_cnt_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rxd};
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg    <= RX_IDLE;
            tcnt_reg     <= '0;
            bitn_reg     <= '0;
            data_reg     <= '0;
            byte_vld_reg <= 1'b0;
            frm_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tcnt_reg     <= tcnt_next;
            bitn_reg     <= bitn_next;
            data_reg     <= data_next;
            byte_vld_reg <= byte_vld_next;
            frm_err_reg  <= frm_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tcnt_next     = tcnt_reg;
        bitn_next     = bitn_reg;
        data_next     = data_reg;
        byte_vld_next = 1'b0;
        frm_err_next  = 1'b0;

        case (state_reg)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_next = RX_START;
                    tcnt_next  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tcnt_reg == 4'(MID_TICK - 1)) begin
                        tcnt_next = '0;
                        bitn_next = '0;
                        // A start bit that is gone by mid-bit was only a glitch.
                        state_next = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tcnt_next = tcnt_reg + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tcnt_reg == 4'(OVERSAMPLE - 1)) begin
                        tcnt_next = '0;
                        data_next = {rx_s, data_reg[7:1]};
                        if (bitn_reg == 3'd7) begin
                            state_next = RX_STOP;
                        end else begin
                            bitn_next = bitn_reg + 3'd1;
                        end
                    end else begin
                        tcnt_next = tcnt_reg + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (tcnt_reg == 4'(OVERSAMPLE - 1)) begin
                        tcnt_next     = '0;
                        byte_vld_next = rx_s;
                        frm_err_next  = !rx_s;
                        state_next    = RX_IDLE;
                    end else begin
                        tcnt_next = tcnt_reg + 4'd1;
                    end
                end
            end
            default: state_next = RX_IDLE;
        endcase

        if (!en) begin
            state_next    = RX_IDLE;
            byte_vld_next = 1'b0;
            frm_err_next  = 1'b0;
        end
    end

    assign byte_vld  = byte_vld_reg;
    assign byte_data = data_reg;
    assign frm_err   = frm_err_reg;
    assign busy      = (state_reg != RX_IDLE);

endmodule

// File: rtl/uart_ins_loader.sv
// UART instruction loader: packs four received bytes (MSB first) into a 32-bit
// word and strobes it out with a running word address and load count.
module uart_ins_loader
    import mips_board_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 8,
    parameter int GAP_BITS = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RXD,
    input  logic              ARM,
    output logic              WE,
    output logic [31:0]       W_Ins,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              BUSY,
    output logic              FRM_ERR,
    output logic [ADDR_W:0]   WORDS
);

    localparam int GAP_TICKS = GAP_BITS * OVERSAMPLE;
    localparam int GAP_W     = $clog2(GAP_TICKS + 1);
    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic       rx_tick;
    logic       rx_byte_vld;
    logic [7:0] rx_byte;
    logic       rx_frm_err;
    logic       rx_busy;

    logic              arm_d_reg;
    logic              we_reg;
    logic [31:0]       ins_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   words_reg;
    logic              frm_err_reg;
    logic [1:0]        bcnt_reg;
    logic [23:0]       shreg_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic              gap_hit;

    uart_rx_core #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk       (CLK),
        .srst      (RST),
        .en        (ARM),
        .rxd       (RXD),
        .tick      (rx_tick),
        .byte_vld  (rx_byte_vld),
        .byte_data (rx_byte),
        .frm_err   (rx_frm_err),
        .busy      (rx_busy)
    );

    assign gap_hit = (gap_cnt_reg == GAP_W'(GAP_TICKS));

    always_ff @(posedge CLK) begin
        if (RST) begin
            arm_d_reg   <= 1'b0;
            we_reg      <= 1'b0;
            ins_reg     <= '0;
            addr_reg    <= '0;
            words_reg   <= '0;
            frm_err_reg <= 1'b0;
            bcnt_reg    <= '0;
            shreg_reg   <= '0;
            gap_cnt_reg <= '0;
        end else begin
            arm_d_reg <= ARM;
            we_reg    <= 1'b0;

            if (!ARM) begin
                bcnt_reg    <= '0;
                shreg_reg   <= '0;
                gap_cnt_reg <= '0;
            end else if (!arm_d_reg) begin
                // Fresh load session: restart addressing and statistics.
                addr_reg    <= '0;
                words_reg   <= '0;
                frm_err_reg <= 1'b0;
                bcnt_reg    <= '0;
                shreg_reg   <= '0;
                gap_cnt_reg <= '0;
            end else begin
                if (we_reg) begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                    if (words_reg != WORDS_MAX) begin
                        words_reg <= words_reg + (ADDR_W + 1)'(1);
                    end
                end

                // Idle time is only measured while a partial word is pending.
                if (rx_busy || (bcnt_reg == 2'd0)) begin
                    gap_cnt_reg <= '0;
                end else if (rx_tick && !gap_hit) begin
                    gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                end

                if (rx_frm_err) begin
                    frm_err_reg <= 1'b1;
                    bcnt_reg    <= '0;
                    shreg_reg   <= '0;
                end else if (rx_byte_vld) begin
                    if (bcnt_reg == 2'(BYTES_PER_WORD - 1)) begin
                        ins_reg  <= {shreg_reg, rx_byte};
                        we_reg   <= 1'b1;
                        bcnt_reg <= '0;
                    end else begin
                        shreg_reg <= {shreg_reg[15:0], rx_byte};
                        bcnt_reg  <= bcnt_reg + 2'd1;
                    end
                end else if (gap_hit) begin
                    bcnt_reg  <= '0;
                    shreg_reg <= '0;
                end
            end
        end
    end

    assign WE      = we_reg;
    assign W_Ins   = ins_reg;
    assign W_Addr  = addr_reg;
    assign BUSY    = rx_busy & ARM;
    assign FRM_ERR = frm_err_reg;
    assign WORDS   = words_reg;

endmodule

// File: tb/tb_uart_ins_loader.sv
// Directed bench for uart_ins_loader at one clock per oversample tick
// (160 clocks per 10-bit UART frame).
module tb_uart_ins_loader;

    localparam int ADDR_W = 8;

    logic              CLK;
    logic              RST;
    logic              RXD;
    logic              ARM;
    logic              WE;
    logic [31:0]       W_Ins;
    logic [ADDR_W-1:0] W_Addr;
    logic              BUSY;
    logic              FRM_ERR;
    logic [ADDR_W:0]   WORDS;

    int checks   = 0;
    int failures = 0;

    int          we_cnt  = 0;
    int          we_long = 0;
    logic        we_prev = 1'b0;
    bit          busy_seen = 1'b0;
    logic [31:0] cap_ins  [64];
    logic [31:0] cap_addr [64];

    uart_ins_loader #(
        .CLK_HZ   (1_600_000),
        .BAUD     (100_000),
        .ADDR_W   (ADDR_W),
        .GAP_BITS (32)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .RXD     (RXD),
        .ARM     (ARM),
        .WE      (WE),
        .W_Ins   (W_Ins),
        .W_Addr  (W_Addr),
        .BUSY    (BUSY),
        .FRM_ERR (FRM_ERR),
        .WORDS   (WORDS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record every write strobe on the falling edge.
    always @(negedge CLK) begin
        if (WE) begin
            if (we_cnt < 64) begin
                cap_ins[we_cnt]  = W_Ins;
                cap_addr[we_cnt] = 32'(W_Addr);
            end
            we_cnt++;
        end
        if (WE && we_prev) we_long++;
        we_prev = WE;
        if (BUSY) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"},      32'(WE),      32'h0);
        chk({tag, "_ins"},     W_Ins,        32'h0);
        chk({tag, "_addr"},    32'(W_Addr),  32'h0);
        chk({tag, "_busy"},    32'(BUSY),    32'h0);
        chk({tag, "_frm_err"}, 32'(FRM_ERR), 32'h0);
        chk({tag, "_words"},   32'(WORDS),   32'h0);
    endtask

    // One 8N1 frame; rst_at >= 0 pulses RST at that clock within the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_at);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 160; i++) begin
            RXD = frame[i / 16];
            RST = (i == rst_at);
            @(posedge CLK);
            #1;
            if (i == rst_at) begin
                RST = 1'b0;
                check_reset_state("t6_rst");
            end
        end
        RXD = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_frame(w[31:24], 1'b1, -1);
        send_frame(w[23:16], 1'b1, -1);
        send_frame(w[15:8],  1'b1, -1);
        send_frame(w[7:0],   1'b1, -1);
    endtask

    initial begin
        RXD = 1'b1;
        ARM = 1'b0;
        RST = 1'b1;
        wait_clks(3);
        check_reset_state("reset");
        RST = 1'b0;
        wait_clks(2);
        ARM = 1'b1;
        wait_clks(4);

        // 1: single word
        send_word(32'h20080005);
        wait_clks(8);
        chk("t1_we_count", 32'(we_cnt), 32'd1);
        chk("t1_ins",      cap_ins[0],  32'h20080005);
        chk("t1_addr",     cap_addr[0], 32'd0);
        chk("t1_words",    32'(WORDS),  32'd1);
        chk("t1_addr_inc", 32'(W_Addr), 32'd1);

        // 2: re-arm, two consecutive words
        ARM = 1'b0;
        wait_clks(3);
        ARM = 1'b1;
        wait_clks(3);
        chk("t2_words_clr", 32'(WORDS), 32'd0);
        send_word(32'h8C010004);
        send_word(32'hAC020008);
        wait_clks(8);
        chk("t2_we_count", 32'(we_cnt), 32'd3);
        chk("t2_ins0",     cap_ins[1],  32'h8C010004);
        chk("t2_addr0",    cap_addr[1], 32'd0);
        chk("t2_ins1",     cap_ins[2],  32'hAC020008);
        chk("t2_addr1",    cap_addr[2], 32'd1);
        chk("t2_words",    32'(WORDS),  32'd2);

        // 3: framing error on byte 2 drops the partial word
        send_frame(8'h20, 1'b1, -1);
        send_frame(8'h08, 1'b0, -1);
        RXD = 1'b1;
        wait_clks(32);
        chk("t3_frm_err",  32'(FRM_ERR), 32'd1);
        chk("t3_no_we",    32'(we_cnt),  32'd3);
        send_word(32'h0000000C);
        wait_clks(8);
        chk("t3_we_count", 32'(we_cnt),  32'd4);
        chk("t3_ins",      cap_ins[3],   32'h0000000C);
        chk("t3_addr",     cap_addr[3],  32'd2);
        chk("t3_sticky",   32'(FRM_ERR), 32'd1);
        chk("t3_words",    32'(WORDS),   32'd3);

        // 4: short low glitch
        busy_seen = 1'b0;
        RXD = 1'b0;
        wait_clks(4);
        RXD = 1'b1;
        wait_clks(40);
        chk("t4_busy_pulse", 32'(busy_seen), 32'd1);
        chk("t4_busy_idle",  32'(BUSY),      32'd0);
        chk("t4_no_we",      32'(we_cnt),    32'd4);

        // 5: gap timeout discards three stale bytes
        send_frame(8'hAA, 1'b1, -1);
        send_frame(8'hBB, 1'b1, -1);
        send_frame(8'hCC, 1'b1, -1);
        wait_clks(33 * 16);
        chk("t5_no_we", 32'(we_cnt), 32'd4);
        send_word(32'h12345678);
        wait_clks(8);
        chk("t5_we_count", 32'(we_cnt), 32'd5);
        chk("t5_ins",      cap_ins[4],  32'h12345678);
        chk("t5_words",    32'(WORDS),  32'd4);

        // 6: reset mid-data, reload, then ARM toggle
        send_frame(8'hFF, 1'b1, 40);
        wait_clks(16);
        chk("t6_no_we", 32'(we_cnt), 32'd5);
        send_word(32'h01020304);
        send_word(32'h05060708);
        wait_clks(8);
        chk("t6_we_count", 32'(we_cnt), 32'd7);
        chk("t6_ins0",     cap_ins[5],  32'h01020304);
        chk("t6_addr0",    cap_addr[5], 32'd0);
        chk("t6_ins1",     cap_ins[6],  32'h05060708);
        chk("t6_addr1",    cap_addr[6], 32'd1);
        chk("t6_words",    32'(WORDS),  32'd2);
        ARM = 1'b0;
        wait_clks(3);
        ARM = 1'b1;
        wait_clks(3);
        chk("t6_rearm_words", 32'(WORDS),  32'd0);
        chk("t6_rearm_addr",  32'(W_Addr), 32'd0);
        chk("t6_ins_held",    W_Ins,       32'h05060708);
        chk("we_one_cycle",   32'(we_long), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
